// File: rtl/wallace_pkg.sv
// Shared constants and tree-shape helpers for the pipelined Wallace multiplier.
package wallace_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_TAG_W = 4;
    localparam int LATENCY   = 4;

    // Rows left after one 3:2 level: each full group of three becomes two,
    // leftover rows pass straight through.
    function automatic int next_rows(input int rows);
        return 2 * (rows / 3) + (rows % 3);
    endfunction

    // Number of 3:2 levels needed to bring `width` partial-product rows down to 2.
    function automatic int red_levels(input int width);
        int rows;
        int lvls;
        rows = width;
        lvls = 0;
        while (rows > 2) begin
            rows = next_rows(rows);
            lvls++;
        end
        return lvls;
    endfunction

    // Row count entering tree level `lvl` (level 0 = raw partial products).
    function automatic int rows_at(input int width, input int lvl);
        int rows;
        rows = width;
        for (int i = 0; i < lvl; i++) begin
            rows = next_rows(rows);
        end
        return rows;
    endfunction

endpackage

// File: rtl/csa_row.sv
// One 3:2 carry-save row: a bank of independent full adders with no carry ripple.
module csa_row #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] sum,
    output logic [DATA_W-1:0] carry
);

    // Per-bit full adder; carry is left unshifted, the caller aligns it.
    always_comb begin
        sum   = a ^ b ^ c;
        carry = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/wallace_mult_pipe.sv
// Four-stage pipelined Wallace-tree multiplier, unsigned or Baugh-Wooley signed
// per operation, with a valid/ready handshake and a sideband tag.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int PW     = 2 * WIDTH;
    localparam int LVLS   = red_levels(WIDTH);
    localparam int HALF   = (LVLS + 1) / 2;
    localparam int ROWS_H = rows_at(WIDTH, HALF);

    logic             stall;
    logic             vld_p1, vld_p2, vld_p3, vld_p4;
    logic [WIDTH-1:0] a_p1, b_p1;
    logic             sgn_p1;
    logic [TAG_W-1:0] tag_p1, tag_p2, tag_p3, tag_p4;
    logic [PW-1:0]    pp [WIDTH];
    logic [PW-1:0]    rows_p2 [ROWS_H];
    logic [PW-1:0]    sum_p3, cry_p3;
    logic [PW-1:0]    prod_p4;

    // The whole pipe freezes only when the output stage is full and unaccepted;
    // any bubble upstream is simply overwritten as data advances.
    assign stall     = vld_p4 & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_p4;
    assign out_p     = prod_p4;
    assign out_tag   = tag_p4;
    assign busy      = vld_p1 | vld_p2 | vld_p3 | vld_p4;

    // Stage valid bits; reset discards everything in flight, including any
    // operand presented during the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            vld_p4 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            vld_p4 <= vld_p3;
        end
    end

    // ---- S1 -> tree: partial products with Baugh-Wooley signed handling ----
    // In signed mode, terms pairing exactly one sign bit are inverted, and the
    // correction 2^WIDTH + 2^(2*WIDTH-1) is dropped into two bit positions no
    // row otherwise occupies, so no extra row enters the tree.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp[i] = '0;
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = (a_p1[j] & b_p1[i])
                           ^ (sgn_p1 & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        pp[0][WIDTH]        = sgn_p1;
        pp[WIDTH-1][PW - 1] = sgn_p1;
    end

    // Carry-save reduction tree; levels below HALF feed S2, the rest feed S3.
    for (genvar k = 0; k < LVLS; k++) begin : g_lvl
        localparam int N_IN  = rows_at(WIDTH, k);
        localparam int N_GRP = N_IN / 3;
        localparam int N_OUT = rows_at(WIDTH, k + 1);

        logic [PW-1:0] src [N_IN];
        logic [PW-1:0] nxt [N_OUT];

        if (k == 0) begin : g_from_pp
            assign src = pp;
        end else if (k == HALF) begin : g_from_p2
            assign src = rows_p2;
        end else begin : g_from_prev
            assign src = g_lvl[k-1].nxt;
        end

        for (genvar g = 0; g < N_GRP; g++) begin : g_csa
            logic [PW-1:0] cy;
            logic          unused_cy_msb;

            csa_row #(.DATA_W(PW)) u_csa (
                .a     (src[3*g]),
                .b     (src[3*g+1]),
                .c     (src[3*g+2]),
                .sum   (nxt[2*g]),
                .carry (cy)
            );

            // Carry weighs one bit more; whatever shifts past the product width is dropped.
            assign nxt[2*g+1]    = {cy[PW-2:0], 1'b0};
            assign unused_cy_msb = cy[PW-1];
        end

        for (genvar r = 0; r < N_IN - 3 * N_GRP; r++) begin : g_pass
            assign nxt[2*N_GRP + r] = src[3*N_GRP + r];
        end
    end

    // S1..S3 datapath registers; no reset needed, validity is tracked separately.
    always_ff @(posedge clk) begin
        if (!stall) begin
            // ---- S1: operands, mode, tag ----
            a_p1    <= in_a;
            b_p1    <= in_b;
            sgn_p1  <= in_signed;
            tag_p1  <= in_tag;
            // ---- S2: rows after the first half of the tree ----
            rows_p2 <= g_lvl[HALF-1].nxt;
            tag_p2  <= tag_p1;
            // ---- S3: final sum/carry pair ----
            sum_p3  <= g_lvl[LVLS-1].nxt[0];
            cry_p3  <= g_lvl[LVLS-1].nxt[1];
            tag_p3  <= tag_p2;
        end
    end

    // ---- S4: carry-propagate add; output registers clear on reset ----
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_p4 <= '0;
            tag_p4  <= '0;
        end else if (!stall) begin
            prod_p4 <= sum_p3 + cry_p3;
            tag_p4  <= tag_p3;
        end
    end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench: directed handshake/latency/reset scenarios on a 16-bit
// instance plus randomized mixed-mode sweeps on 8-bit and 32-bit instances.
module tb_wallace_mult_pipe;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           in_signed = 1'b0;
    logic [3:0]     in_tag = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_p;
    logic [3:0]     out_tag;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int outs   = 0;
    int cyc    = 0;

    logic [63:0] q_p [$];
    logic [3:0]  q_t [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    wallace_mult_pipe #(.WIDTH(W), .TAG_W(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference product: sign-extend (if signed) to 64 bits, multiply, keep 2*w bits.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int w);
        logic [63:0] ax, bx, r;
        ax = {32'd0, a};
        bx = {32'd0, b};
        if (s && a[w-1]) ax = ax | (~64'd0 << w);
        if (s && b[w-1]) bx = bx | (~64'd0 << w);
        r = ax * bx;
        if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
        return r;
    endfunction

    // Random operand biased toward the extremes of a w-bit value.
    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return mask;
            2:       return 32'd1 << (w - 1);
            3:       return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom & mask;
        endcase
    endfunction

    // Scoreboard for the 16-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            q_p.delete();
            q_t.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q_p.size() == 0) begin
                    check_eq("spurious_out16", 64'd1, 64'd0);
                end else begin
                    check_eq("p16", 64'(out_p), q_p.pop_front());
                    check_eq("tag16", 64'(out_tag), 64'(q_t.pop_front()));
                end
                outs++;
            end
            if (in_valid && in_ready) begin
                q_p.push_back(model(32'(in_a), 32'(in_b), in_signed, W));
                q_t.push_back(in_tag);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [3:0] t);
        logic ok;
        in_a = a;
        in_b = b;
        in_signed = s;
        in_tag = t;
        in_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check_eq("send_timeout", 64'd0, 64'd1);
    endtask

    // Randomized 8-bit and 32-bit instances, each with its own driver and scoreboard.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int SW = (gi == 0) ? 8 : 32;

        logic            s_rst = 1'b1;
        logic            s_iv = 1'b0;
        logic            s_ir;
        logic [SW-1:0]   s_a = '0;
        logic [SW-1:0]   s_b = '0;
        logic            s_sg = 1'b0;
        logic [3:0]      s_ti = '0;
        logic            s_ov;
        logic            s_or = 1'b0;
        logic [2*SW-1:0] s_p;
        logic [3:0]      s_to;
        logic            s_busy;
        logic            s_done = 1'b0;
        int              s_acc = 0;
        int              s_outs = 0;
        logic [63:0]     sq_p [$];
        logic [3:0]      sq_t [$];

        wallace_mult_pipe #(.WIDTH(SW), .TAG_W(4)) u_dut (
            .clk       (clk),
            .rst       (s_rst),
            .in_valid  (s_iv),
            .in_ready  (s_ir),
            .in_a      (s_a),
            .in_b      (s_b),
            .in_signed (s_sg),
            .in_tag    (s_ti),
            .out_valid (s_ov),
            .out_ready (s_or),
            .out_p     (s_p),
            .out_tag   (s_to),
            .busy      (s_busy)
        );

        always @(negedge clk) begin
            if (s_rst) begin
                sq_p.delete();
                sq_t.delete();
            end else begin
                if (s_ov && s_or) begin
                    if (sq_p.size() == 0) begin
                        check_eq("spurious_sweep", 64'd1, 64'd0);
                    end else begin
                        check_eq("p_sweep", 64'(s_p), sq_p.pop_front());
                        check_eq("tag_sweep", 64'(s_to), 64'(sq_t.pop_front()));
                    end
                    s_outs++;
                end
                if (s_iv && s_ir) begin
                    sq_p.push_back(model(32'(s_a), 32'(s_b), s_sg, SW));
                    sq_t.push_back(s_ti);
                    s_acc++;
                end
            end
        end

        initial begin
            repeat (3) @(posedge clk);
            #1;
            s_rst = 1'b0;
            for (int c = 0; c < 8000 && s_acc < 1000; c++) begin
                s_iv = ($urandom_range(0, 3) != 0);
                s_or = ($urandom_range(0, 4) != 0);
                s_a  = SW'(pick(SW));
                s_b  = SW'(pick(SW));
                s_sg = 1'($urandom_range(0, 1));
                s_ti = 4'($urandom);
                @(posedge clk);
                #1;
            end
            s_iv = 1'b0;
            s_or = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            check_eq("sweep_accepted", 64'(s_acc), 64'd1000);
            check_eq("sweep_emitted", 64'(s_outs), 64'd1000);
            check_eq("sweep_drain", 64'(sq_p.size()), 64'd0);
            s_done = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   o0;
        int   c0;
        logic flag;

        // Reset with an operand offered: it must be ignored.
        in_valid = 1'b1;
        in_a = 16'h1234;
        in_b = 16'h0101;
        in_tag = 4'h9;
        repeat (3) step();
        in_valid = 1'b0;
        step();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_out_p", 64'(out_p), 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        #2;
        check_eq("ready_after_rst", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        // Unsigned corner and latency.
        send(16'hFFFF, 16'hFFFF, 1'b0, 4'd3);
        n = 1;
        while (!out_valid && n < 20) begin step(); n++; end
        check_eq("latency", 64'(n), 64'd4);
        check_eq("p_ffff_u", 64'(out_p), 64'hFFFE0001);
        check_eq("tag_ffff_u", 64'(out_tag), 64'd3);

        // Signed corners back-to-back; results on consecutive cycles.
        send(16'h8000, 16'h8000, 1'b1, 4'd5);
        send(16'hFFFF, 16'h0002, 1'b1, 4'd6);
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        check_eq("p_min_sq", 64'(out_p), 64'h40000000);
        check_eq("tag_min_sq", 64'(out_tag), 64'd5);
        step();
        check_eq("b2b_valid", 64'(out_valid), 64'd1);
        check_eq("p_m1x2", 64'(out_p), 64'hFFFFFFFE);
        check_eq("tag_m1x2", 64'(out_tag), 64'd6);
        repeat (6) step();

        // Backpressure mid-stream.
        o0 = outs;
        for (int i = 0; i < 6; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 4'(i));
        out_ready = 1'b0;
        in_a = 16'($urandom);
        in_valid = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_in_ready", 64'(in_ready), 64'd0);
            check_eq("stall_out_valid", 64'(out_valid), 64'd1);
            check_eq("stall_busy", 64'(busy), 64'd1);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 6; i < 10; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 4'(i));
        repeat (8) step();
        check_eq("bp_count", 64'(outs - o0), 64'd10);
        check_eq("bp_drain", 64'(q_p.size()), 64'd0);

        // Full pipe with simultaneous in/out transfers.
        o0 = outs;
        c0 = cyc;
        for (int i = 0; i < 4; i++) send(16'(pick(W)), 16'(pick(W)), 1'($urandom), 4'($urandom));
        for (int i = 0; i < 20; i++) begin
            check_eq("full_out_valid", 64'(out_valid), 64'd1);
            send(16'(pick(W)), 16'(pick(W)), 1'($urandom), 4'($urandom));
        end
        check_eq("full_cycles", 64'(cyc - c0), 64'd24);
        repeat (8) step();
        check_eq("full_count", 64'(outs - o0), 64'd24);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 4'(i + 1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_out_p", 64'(out_p), 64'd0);
        check_eq("midrst_out_tag", 64'(out_tag), 64'd0);
        flag = 1'b0;
        repeat (8) begin
            step();
            if (out_valid || busy) flag = 1'b1;
        end
        check_eq("midrst_quiet", 64'(flag), 64'd0);
        send(16'h7FFF, 16'h8001, 1'b1, 4'hA);
        n = 1;
        while (!out_valid && n < 20) begin step(); n++; end
        check_eq("latency_after_rst", 64'(n), 64'd4);
        repeat (4) step();

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a      = 16'(pick(W));
            in_b      = 16'(pick(W));
            in_signed = 1'($urandom_range(0, 1));
            in_tag    = 4'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        check_eq("rand16_drain", 64'(q_p.size()), 64'd0);

        n = 0;
        while (!(g_sweep[0].s_done && g_sweep[1].s_done) && n < 20000) begin
            step();
            n++;
        end
        check_eq("sweeps_done", 64'(g_sweep[0].s_done && g_sweep[1].s_done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wallace_mult_pipe.md
WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; legal range 4..32.
REQ-002 Parameter TAG_W, default 4: width of the sideband tag carried alongside each operation.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand pair presented.
REQ-006 in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 in_a  input  WIDTH  multiplicand.
REQ-008 in_b  input  WIDTH  multiplier.
REQ-009 in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
REQ-010 in_tag  input  TAG_W  sideband tag; returned unchanged with its product.
REQ-011 out_valid  output  1  product available.
REQ-012 out_ready  input  1  consumer accepts the product this cycle.
REQ-013 out_p  output  2*WIDTH  full-width product.
REQ-014 out_tag  output  TAG_W  tag of the operation on out_p.
REQ-015 busy  output  1  at least one operation held in any pipeline stage.

Function
REQ-016 A transfer in occurs on a cycle with in_valid && in_ready; a transfer out occurs on a cycle with out_valid && out_ready.
REQ-017 Pipeline has 4 register stages: S1 registers operands, mode and tag; S2 registers the partial-product rows after the first ceil(L/2) 3:2 reduction levels; S3 registers the final two rows; S4 registers the carry-propagate sum. L is the number of 3:2 levels needed to reduce WIDTH rows to 2.
REQ-018 Latency SHALL be exactly 4 cycles from the input-transfer edge to out_valid, with no stall.
REQ-019 Throughput SHALL be one operation per cycle while out_ready is held at 1.
REQ-020 stall = out_valid && !out_ready; while stall is 1, every stage holds its data and valid bit, and in_ready = 0.
REQ-021 in_ready = !stall, combinationally; in_ready does not depend on in_valid.
REQ-022 Each stage carries its own valid bit; bubbles propagate, and a bubble stage is overwritten without stalling.
REQ-023 Unsigned mode: out_p = in_a * in_b, exact, modulo 2^(2*WIDTH).
REQ-024 Signed mode: out_p = the two's-complement product of in_a and in_b, exact in 2*WIDTH bits. This includes (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
REQ-025 Signed handling uses Baugh-Wooley partial-product inversion plus correction constants, gated per operation by the stored mode bit. Mode changes between consecutive operations take effect with no bubble.
REQ-026 Reduction uses 3:2 carry-save rows only. Each row's carry vector is shifted left 1 bit before the next level. Bits above 2*WIDTH-1 are discarded.
REQ-027 out_tag and out_p SHALL always belong to the same operation; operations exit in acceptance order.
REQ-028 busy = OR of the four stage valid bits.
REQ-029 When a transfer out and a transfer in occur on the same cycle with the pipeline full, both complete and no operation is lost or duplicated.

Reset
REQ-030 While rst is high on a clock edge, all stage valid bits clear, out_valid = 0, busy = 0, out_p = 0 and out_tag = 0.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-032 Reset mid-operation SHALL discard all in-flight operations; no product from before reset ever appears at the output.
REQ-033 Input transfers are ignored in any cycle where rst is high.

Structure
REQ-034 Shared package wallace_pkg holds: the default WIDTH and TAG_W, the constant LATENCY = 4, and a function computing the number of reduction levels L from WIDTH.
REQ-035 One sub-module, csa_row, is a parametrised 3:2 carry-save row with inputs a, b, c and outputs sum and carry. It is instantiated generatively across the tree levels.
REQ-036 The final carry-propagate adder is a behavioural "+" in S4; no other sub-modules.

Verification (WIDTH=16, TAG_W=4)
REQ-037 Unsigned: a=0xFFFF, b=0xFFFF, signed=0, tag=3 -> 4 cycles later out_p=0xFFFE0001, out_tag=3.
REQ-038 Signed: a=0x8000, b=0x8000 -> out_p=0x40000000; then a=0xFFFF, b=0x0002 -> out_p=0xFFFFFFFE. Issue these back-to-back; outputs appear on consecutive cycles.
REQ-039 Backpressure: stream 10 random operations, drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, all 10 products emerge in order and match the golden model.
REQ-040 Simultaneous transfer: pipeline full, out_ready=1, in_valid=1 continuously for 20 cycles -> 20 outputs, no gaps, no duplicates.
REQ-041 Reset mid-flight: accept 3 operations, assert rst for 1 cycle -> out_valid stays 0 afterwards and busy=0; the next operation has latency 4.
REQ-042 Sweep WIDTH=8 and WIDTH=32 with 1000 random mixed-mode operations each -> zero mismatches against the golden model.
